// File: rtl/fs.sv
// Single-bit full subtractor with a registered output stage and an optional
// bit-serial word engine (LSB-first, WIDTH bits per word).
// Optional feature macro: FS_SERIAL_EN. When it is undefined, sof is ignored and
// the word outputs are tied to zero.
module fs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             bin,
  output logic             d,
  output logic             bout,
  input  logic             in_valid,
  input  logic             sof,
  output logic             d_q,
  output logic             bout_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_borrow,
  output logic             word_done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic beff_c;
  logic diff_c;
  logic brw_c;

  // Combinational core, always active
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

  // Same subtraction with the effective borrow-in feeding the clocked stage
  assign diff_c = a ^ b ^ beff_c;
  assign brw_c  = (~a & b) | (~a & beff_c) | (b & beff_c);

  // Registered single-bit result; outputs hold while in_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= 1'b0;
      bout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d_q    <= diff_c;
        bout_q <= brw_c;
      end
    end
  end

`ifdef FS_SERIAL_EN
  logic             borrow_reg;
  logic [WIDTH-2:0] sh;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_cur_c;
  logic             last_c;
  logic [WIDTH-1:0] word_next_c;

  // sof restarts the word: bit 0 takes bin, otherwise chain the stored borrow
  assign beff_c      = sof ? bin : borrow_reg;
  assign cnt_cur_c   = sof ? '0 : cnt;
  assign last_c      = (cnt_cur_c == CW'(WIDTH - 1));
  // sh holds the most recent WIDTH-1 difference bits, newest at the top
  assign word_next_c = {diff_c, sh};

  // Serial word assembly; idle cycles freeze count, shift state and borrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_reg  <= 1'b0;
      sh          <= '0;
      cnt         <= '0;
      word        <= '0;
      word_borrow <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (in_valid) begin
        borrow_reg <= brw_c;
        sh         <= word_next_c[WIDTH-1:1];
        if (last_c) begin
          word        <= word_next_c;
          word_borrow <= brw_c;
          word_done   <= 1'b1;
          cnt         <= '0;
        end else begin
          cnt <= cnt_cur_c + CW'(1);
        end
      end
    end
  end
`else
  logic sof_unused;

  assign sof_unused  = sof;
  assign beff_c      = bin;
  assign word        = '0;
  assign word_borrow = 1'b0;
  assign word_done   = 1'b0;
`endif

endmodule

// File: tb/tb_fs.sv
// Self-checking bench for fs: combinational truth table, async reset,
// registered latency/hold, and (when FS_SERIAL_EN is defined) serial words.
module tb_fs;

  localparam int unsigned W = 8;
`ifdef FS_SERIAL_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a, b, bin, in_valid, sof;
  logic         d, bout, d_q, bout_q, out_valid;
  logic [W-1:0] word;
  logic         word_borrow, word_done;

  typedef struct packed { logic d; logic b; } bit_t;
  typedef struct packed { logic [W-1:0] w; logic b; } word_t;

  bit_t  reg_q[$];
  word_t word_q[$];

  int           passed = 0;
  int           total  = 0;
  logic         m_borrow = 1'b0;
  logic         last_d = 1'b0;
  logic         last_b = 1'b0;
  logic [W-1:0] last_word = '0;
  logic         last_wb = 1'b0;

  fs #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin), .d(d), .bout(bout),
    .in_valid(in_valid), .sof(sof), .d_q(d_q), .bout_q(bout_q),
    .out_valid(out_valid), .word(word), .word_borrow(word_borrow),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock of stimulus; expectations are queued before the edge, popped after it
  task automatic step(input logic ia, input logic ib, input logic ibin,
                      input logic isof, input logic iv, input logic ilast);
    logic       beff;
    logic [1:0] t;
    bit_t       e;
    word_t      ew;
    logic       exp_done;
    a = ia; b = ib; bin = ibin; sof = isof; in_valid = iv;
    beff = (SERIAL && !isof) ? m_borrow : ibin;
    t = {1'b0, ia} - {1'b0, ib} - {1'b0, beff};
    if (iv) begin
      e.d = t[0];
      e.b = t[1];
      reg_q.push_back(e);
      m_borrow = t[1];
    end
    exp_done = SERIAL && iv && ilast;
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(iv));
    if (iv) begin
      check("reg_sb_nonempty", 32'(reg_q.size() != 0), 32'd1);
      if (reg_q.size() != 0) begin
        e = reg_q.pop_front();
        last_d = e.d;
        last_b = e.b;
      end
    end
    check("d_q", 32'(d_q), 32'(last_d));
    check("bout_q", 32'(bout_q), 32'(last_b));
    check("word_done", 32'(word_done), 32'(exp_done));
    if (word_done === 1'b1) begin
      check("word_sb_nonempty", 32'(word_q.size() != 0), 32'd1);
      if (word_q.size() != 0) begin
        ew = word_q.pop_front();
        last_word = ew.w;
        last_wb = ew.b;
      end
    end
    check("word", 32'(word), 32'(last_word));
    check("word_borrow", 32'(word_borrow), 32'(last_wb));
  endtask

  // Full LSB-first word with sof on bit 0, optional idle cycle after every bit
  task automatic send_word(input logic [W-1:0] x, input logic [W-1:0] y, input bit gaps);
    word_t ew;
    if (SERIAL) begin
      ew.w = x - y;
      ew.b = (x < y);
      word_q.push_back(ew);
    end
    for (int i = 0; i < W; i++) begin
      step(x[i], y[i], 1'b0, i == 0, 1'b1, i == W - 1);
      if (gaps) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d_tab;
    logic [7:0] b_tab;
    logic [2:0] v;
    d_tab = 8'h96;
    b_tab = 8'hD4;

    rst_n = 1'b0; a = 1'b0; b = 1'b0; bin = 1'b0; in_valid = 1'b0; sof = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d_q", 32'(d_q), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_word_done", 32'(word_done), 32'd0);

    // Exhaustive combinational table, independent of clock and reset
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {bin, b, a} = v;
      #10;
      check($sformatf("comb_d_%0d", i), 32'(d), 32'(d_tab[i]));
      check($sformatf("comb_bout_%0d", i), 32'(bout), 32'(b_tab[i]));
    end
    rst_n = 1'b1;

    // Registered latency: one valid cycle, then out_valid drops and d_q/bout_q hold
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("lat_d_q", 32'(d_q), 32'd1);
    check("lat_bout_q", 32'(bout_q), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Serial words: basic, underflow, then a restart mid-word with gaps
    send_word(8'h05, 8'h03, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (SERIAL) begin
      check("w1_word", 32'(word), 32'h02);
      check("w1_borrow", 32'(word_borrow), 32'd0);
    end
    send_word(8'h00, 8'h01, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (SERIAL) begin
      check("w2_word", 32'(word), 32'hFF);
      check("w2_borrow", 32'(word_borrow), 32'd1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h10, 8'h0F, 1'b1);
    if (SERIAL) begin
      check("w3_word", 32'(word), 32'h01);
      check("w3_borrow", 32'(word_borrow), 32'd0);
    end
    // Back-to-back word right after completion
    send_word(8'h3C, 8'h5A, 1'b0);

    // Async reset mid-cycle while out_valid is high and registers are non-zero
    send_word(8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_d_q", 32'(d_q), 32'd0);
    check("arst_bout_q", 32'(bout_q), 32'd0);
    check("arst_word", 32'(word), 32'd0);
    check("arst_word_borrow", 32'(word_borrow), 32'd0);
    check("arst_word_done", 32'(word_done), 32'd0);
    m_borrow = 1'b0; last_d = 1'b0; last_b = 1'b0; last_word = '0; last_wb = 1'b0;
    reg_q.delete();
    word_q.delete();
    rst_n = 1'b1;

    // First valid bit after reset without sof uses a cleared stored borrow
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
